// File: rtl/blob_arb_pkg.sv
// Shared definitions for the blob round-robin arbiter: state encoding,
// default source-index width and the round-robin wrap helper.
package blob_arb_pkg;

  localparam int unsigned SRC_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_e;

  // Index following id, wrapping modulo n.
  function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
    return (id + 32'd1 >= n) ? 32'd0 : id + 32'd1;
  endfunction

endpackage

// File: rtl/blob_rr_pick.sv
// Combinational round-robin pick: lowest requesting index above last_id,
// otherwise the lowest requesting index overall.
module blob_rr_pick
  import blob_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SRC_W   = SRC_W_DEF
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_id,
  output logic [SRC_W-1:0]   pick_id_c,
  output logic               pick_vld_c
);

  logic [NUM_SRC-1:0]            mask_c;
  logic [NUM_SRC-1:0]            req_hi_c;
  logic [NUM_SRC-1:0]            vec_c;
  logic [NUM_SRC-1:0]            onehot_c;
  logic [NUM_SRC:0][SRC_W-1:0]   id_chain_c;

  assign req_hi_c      = req & mask_c;
  assign vec_c         = (|req_hi_c) ? req_hi_c : req;
  // Isolate the lowest set bit of the search vector.
  assign onehot_c      = vec_c & (~vec_c + NUM_SRC'(1));
  assign id_chain_c[0] = '0;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_bit
    localparam int unsigned G = g;
    assign mask_c[g]         = (G >= rr_next(32'(last_id), NUM_SRC));
    assign id_chain_c[g+1]   = id_chain_c[g] | (onehot_c[g] ? SRC_W'(G) : SRC_W'(0));
  end

  assign pick_id_c  = id_chain_c[NUM_SRC];
  assign pick_vld_c = |req;

endmodule

// File: rtl/blob_arb.sv
// Blob-granular round-robin arbiter in front of the width converter.
// Optional stall watchdog with forced eop close: define BLOB_ARB_TIMEOUT_EN.
module blob_arb
  import blob_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned SRC_W          = SRC_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_din,
  input  logic [NUM_SRC-1:0]            src_din_en,
  input  logic [NUM_SRC-1:0]            src_din_eop,
  output logic [NUM_SRC-1:0]            src_din_rdy,
  output logic [DATA_WIDTH-1:0]         blob_dout,
  output logic                          blob_dout_en,
  output logic                          blob_dout_eop,
  input  logic                          blob_dout_rdy,
  output logic                          grant_vld,
  output logic [SRC_W-1:0]              grant_id,
  output logic                          err_timeout,
  output logic [SRC_W-1:0]              err_src
);

  if ((1 << SRC_W) < NUM_SRC || NUM_SRC < 2 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("blob_arb: invalid parameter combination");
  end

  state_e                         state, state_nxt;
  logic [SRC_W-1:0]               grant_id_nxt;
  logic [SRC_W-1:0]               last_id, last_id_nxt;
  logic [SRC_W-1:0]               pick_id_c;
  logic                           pick_vld_c;
  logic [NUM_SRC-1:0]             hit_c;
  logic [NUM_SRC:0][DATA_WIDTH-1:0] data_chain_c;
  logic [DATA_WIDTH-1:0]          sel_data_c;
  logic                           sel_en_c;
  logic                           sel_eop_c;

  blob_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req        (src_din_en),
    .last_id    (last_id),
    .pick_id_c  (pick_id_c),
    .pick_vld_c (pick_vld_c)
  );

  // One-hot AND-OR mux of the owning source's beat.
  assign data_chain_c[0] = '0;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sel
    localparam int unsigned G = g;
    assign hit_c[g]          = (grant_id == SRC_W'(G));
    assign data_chain_c[g+1] = data_chain_c[g] |
                               ({DATA_WIDTH{hit_c[g]}} & src_din[G*DATA_WIDTH +: DATA_WIDTH]);
  end

  assign sel_data_c = data_chain_c[NUM_SRC];
  assign sel_en_c   = |(hit_c & src_din_en);
  assign sel_eop_c  = |(hit_c & src_din_eop);
  assign grant_vld  = (state == BUSY);

`ifdef BLOB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
  logic             err_timeout_nxt;
  logic [SRC_W-1:0] err_src_nxt;
`else
  assign err_timeout = 1'b0;
  assign err_src     = '0;
`endif

  // Next-state and pass-through datapath.
  always_comb begin
    state_nxt     = state;
    grant_id_nxt  = grant_id;
    last_id_nxt   = last_id;
    blob_dout     = '0;
    blob_dout_en  = 1'b0;
    blob_dout_eop = 1'b0;
    src_din_rdy   = '0;
`ifdef BLOB_ARB_TIMEOUT_EN
    stall_cnt_nxt   = stall_cnt;
    err_timeout_nxt = 1'b0;
    err_src_nxt     = err_src;
`endif
    case (state)
      IDLE: begin
        if (pick_vld_c) begin
          grant_id_nxt = pick_id_c;
          state_nxt    = BUSY;
`ifdef BLOB_ARB_TIMEOUT_EN
          stall_cnt_nxt = '0;
`endif
        end
      end
      BUSY: begin
        blob_dout     = sel_data_c;
        blob_dout_en  = sel_en_c;
        blob_dout_eop = sel_eop_c;
        src_din_rdy   = hit_c & {NUM_SRC{blob_dout_rdy}};
        if (sel_en_c && blob_dout_rdy) begin
`ifdef BLOB_ARB_TIMEOUT_EN
          stall_cnt_nxt = '0;
`endif
          if (sel_eop_c) begin
            last_id_nxt = grant_id;
            state_nxt   = IDLE;
          end
        end
`ifdef BLOB_ARB_TIMEOUT_EN
        // Only source-side stalls count; converter backpressure does not.
        else if (!sel_en_c) begin
          if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_timeout_nxt = 1'b1;
            err_src_nxt     = grant_id;
            state_nxt       = ABORT;
          end else begin
            stall_cnt_nxt = stall_cnt + 1'b1;
          end
        end
`endif
      end
`ifdef BLOB_ARB_TIMEOUT_EN
      ABORT: begin
        blob_dout_en  = 1'b1;
        blob_dout_eop = 1'b1;
        if (blob_dout_rdy) begin
          last_id_nxt = grant_id;
          state_nxt   = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      last_id  <= SRC_W'(NUM_SRC - 1);
`ifdef BLOB_ARB_TIMEOUT_EN
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
      err_src     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      grant_id <= grant_id_nxt;
      last_id  <= last_id_nxt;
`ifdef BLOB_ARB_TIMEOUT_EN
      stall_cnt   <= stall_cnt_nxt;
      err_timeout <= err_timeout_nxt;
      err_src     <= err_src_nxt;
`endif
    end
  end

endmodule

// File: doc/blob_arb.md
# blob_arb

Round-robin arbiter that shares one downstream bus-width converter between NUM_SRC independent blob producers. Blob-granular: a grant is held from the first beat to the eop beat of one blob, so blobs from different sources never interleave. Sits directly in front of the m-to-n width converter's blob_din port. Data and handshake pass through combinationally once granted.

## Interface
- NUM_SRC, 4, number of requesting sources (2..16)
- DATA_WIDTH, 512, blob beat width; equals the converter's IN_WIDTH
- SRC_W, 4, width of source index; must satisfy 2^SRC_W >= NUM_SRC
- TIMEOUT_CYCLES, 1024, stall limit for the watchdog (only with BLOB_ARB_TIMEOUT_EN)

- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- src_din  in  NUM_SRC*DATA_WIDTH  source beats; source i at [i*DATA_WIDTH +: DATA_WIDTH]
- src_din_en  in  NUM_SRC  source i has a beat valid; also its request
- src_din_eop  in  NUM_SRC  beat is last of blob
- src_din_rdy  out  NUM_SRC  beat accepted when en & rdy
- blob_dout  out  DATA_WIDTH  to converter blob_din
- blob_dout_en  out  1  to converter blob_din_en
- blob_dout_eop  out  1  to converter blob_din_eop
- blob_dout_rdy  in  1  from converter blob_din_rdy
- grant_vld  out  1  a source owns the port
- grant_id  out  SRC_W  owning source index
- err_timeout  out  1  one-cycle pulse on watchdog abort
- err_src  out  SRC_W  source aborted by last timeout

## Operation
- FSM states: IDLE, BUSY, ABORT (ABORT exists only with BLOB_ARB_TIMEOUT_EN).
- IDLE: if any src_din_en bit set, select first set bit searching from last_id+1 upward, wrapping modulo NUM_SRC; grant_id <= selection; -> BUSY. No requests: stay.
- BUSY: blob_dout = src_din[grant_id], blob_dout_en = src_din_en[grant_id], blob_dout_eop = src_din_eop[grant_id]; src_din_rdy[grant_id] = blob_dout_rdy; every other rdy bit 0.
- Transfer = blob_dout_en & blob_dout_rdy. Transfer with eop: last_id <= grant_id; -> IDLE.
- Source may drop en mid-blob (stall); grant is kept.
- IDLE/ABORT: all src_din_rdy 0; blob_dout_en 0 in IDLE.
- grant_vld = (state == BUSY).
- Requests from a single source only: that source is re-granted after every blob.

## Timing
- Reset values: state IDLE, grant_id 0, last_id NUM_SRC-1 (so source 0 wins first), grant_vld 0, blob_dout_en 0, blob_dout_eop 0, src_din_rdy 0, err_timeout 0, err_src 0; blob_dout 0.
- Grant latency: request seen in IDLE at cycle t -> BUSY, first transfer possible at t+1.
- One-cycle bubble between consecutive blobs (eop transfer -> IDLE -> next grant).
- Single-beat blob (en & eop first beat): BUSY for exactly one cycle if rdy high.
- Data path zero latency in BUSY: purely combinational mux, no registers.
- Reset asserted mid-blob: immediate return to IDLE, all outputs to reset values; partial blob discarded, converter is reset by same rst domain.

## Configuration
- BLOB_ARB_TIMEOUT_EN defined: stall counter clears on every transfer and on entering BUSY, increments each BUSY cycle with src_din_en[grant_id] low (cycles with en high but rdy low do not count). At TIMEOUT_CYCLES-1: err_timeout pulses, err_src <= grant_id, -> ABORT. ABORT drives blob_dout = 0, blob_dout_en = 1, blob_dout_eop = 1 until blob_dout_rdy; then last_id <= grant_id, -> IDLE. Closes the converter's partial blob.
- Not defined: no counter, no ABORT; err_timeout and err_src tied 0; a stalled source holds the port indefinitely.

## Structure
- Shared package: state encoding constants (IDLE, BUSY, ABORT), SRC_W default, round-robin helper function.
- One sub-module: blob_rr_pick (combinational: request vector + last_id -> next id + valid).

## Test plan
- Reset, src 0 sends 3-beat blob, rdy=1 -> grant_id 0 at cycle 1, beats out cycles 1-3, eop on 3, IDLE cycle 4.
- src 1,2,3 all request 2-beat blobs simultaneously -> order 1? no: first grant 0 skipped (no req) -> grants 1,2,3, one bubble between each.
- rdy toggled 1/0 every cycle during 4-beat blob -> exactly 4 transfers, src_din_rdy follows blob_dout_rdy only for owner.
- src 2 stalls 1024 cycles mid-blob (TIMEOUT_EN) -> err_timeout pulse, err_src 2, one zero-data eop beat, src 3 granted next.
- rst_n low during beat 2 of 5 -> all outputs to reset values same cycle; after release src 0 granted first.
